// File: rtl/wb_arbiter_if.sv
// Exception codes and the writeback arbiter port bundle.
// slave: arbiter side (src_* in; busy, wb_*, overflow out).
// master: execution units / ROB side.
`ifndef RobDepth
`define RobDepth 16
`endif

package wb_arbiter_pkg;
  typedef enum logic [3:0] {
    EXP_NONE         = 4'd0,
    EXP_I_MISS_ALIGN = 4'd1,
    EXP_I_ACC_FAULT  = 4'd2,
    EXP_ILL_INSN     = 4'd3,
    EXP_BREAK        = 4'd4,
    EXP_L_MISS_ALIGN = 4'd5,
    EXP_L_ACC_FAULT  = 4'd6,
    EXP_S_MISS_ALIGN = 4'd7,
    EXP_S_ACC_FAULT  = 4'd8,
    EXP_ECALL        = 4'd9
  } ExpCode_t;
endpackage

interface wb_arbiter_if #(
  parameter int SRC = 4,
  parameter int ROB = 4
);
  import wb_arbiter_pkg::*;

  localparam int EW = $bits(ExpCode_t);

  logic              flush_;
  logic [SRC-1:0]     src_e_;
  logic [SRC*ROB-1:0] src_rob_id;
  logic [SRC-1:0]     src_exp_;
  logic [SRC*EW-1:0]  src_exp_code;
  logic [SRC-1:0]     src_pred_miss_;
  logic [SRC-1:0]     src_jump_miss_;
  logic [SRC-1:0]     src_busy;
  logic               wb_e_;
  logic [ROB-1:0]     wb_rob_id;
  logic               wb_exp_;
  ExpCode_t           wb_exp_code;
  logic               wb_pred_miss_;
  logic               wb_jump_miss_;
  logic               overflow;

  modport master (
    output flush_, src_e_, src_rob_id,
    output src_exp_, src_exp_code,
    output src_pred_miss_, src_jump_miss_,
    input  src_busy, wb_e_, wb_rob_id,
    input  wb_exp_, wb_exp_code,
    input  wb_pred_miss_, wb_jump_miss_,
    input  overflow
  );

  modport slave (
    input  flush_, src_e_, src_rob_id,
    input  src_exp_, src_exp_code,
    input  src_pred_miss_, src_jump_miss_,
    output src_busy, wb_e_, wb_rob_id,
    output wb_exp_, wb_exp_code,
    output wb_pred_miss_, wb_jump_miss_,
    output overflow
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source completion FIFOs, round-robin
// grant of one writeback per cycle to the ROB; flush empties all.
// Ports: clk, reset_ (async, active-low), bus (wb_arbiter_if.slave).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ROB_DEPTH  = `RobDepth,
  parameter int ROB        = $clog2(ROB_DEPTH),
  parameter int SRC        = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         reset_,
  wb_arbiter_if.slave bus
);

  localparam int EW = $bits(ExpCode_t);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(SRC);

  typedef struct packed {
    logic [ROB-1:0] rob_id;
    logic           exp_;
    ExpCode_t       exp_code;
    logic           pred_miss_;
    logic           jump_miss_;
  } ent_t;

  ent_t          mem_q [SRC][FIFO_DEPTH];
  ent_t          mem_d [SRC][FIFO_DEPTH];
  logic [PW-1:0] rp_q  [SRC];
  logic [PW-1:0] rp_d  [SRC];
  logic [PW-1:0] wp_q  [SRC];
  logic [PW-1:0] wp_d  [SRC];
  logic [CW-1:0] cnt_q [SRC];
  logic [CW-1:0] cnt_d [SRC];
  logic [RW-1:0] rr_q;
  logic [RW-1:0] rr_d;
  logic          ovf_q;
  logic          ovf_d;

  logic [SRC-1:0] full;
  logic [SRC-1:0] req;
  logic [SRC-1:0] push;
  logic [SRC-1:0] pop;
  logic [SRC-1:0] drop;
  ent_t           in_ent [SRC];
  logic           gnt_v;
  logic [RW-1:0]  gnt;
  logic           wb_v;
  ent_t           head;

  always_comb begin
    full = '0;
    req  = '0;
    push = '0;
    drop = '0;
    for (int i = 0; i < SRC; i++) begin
      full[i] = cnt_q[i] == CW'(FIFO_DEPTH);
      req[i]  = cnt_q[i] != '0;
      push[i] = !bus.src_e_[i] && bus.flush_ && !full[i];
      drop[i] = !bus.src_e_[i] && bus.flush_ && full[i];
      in_ent[i].rob_id     = bus.src_rob_id[i*ROB +: ROB];
      in_ent[i].exp_       = bus.src_exp_[i];
      in_ent[i].exp_code   =
        ExpCode_t'(bus.src_exp_code[i*EW +: EW]);
      in_ent[i].pred_miss_ = bus.src_pred_miss_[i];
      in_ent[i].jump_miss_ = bus.src_jump_miss_[i];
    end
  end

  // Scan from the farthest offset down so the offset closest
  // to rr_q is the last to overwrite, i.e. it wins.
  always_comb begin
    gnt_v = 1'b0;
    gnt   = rr_q;
    for (int k = SRC - 1; k >= 0; k--) begin
      if (req[(int'(rr_q) + k) % SRC]) begin
        gnt_v = 1'b1;
        gnt   = RW'((int'(rr_q) + k) % SRC);
      end
    end
  end

  assign wb_v = gnt_v && bus.flush_;
  assign head = mem_q[gnt][rp_q[gnt]];

  always_comb begin
    pop = '0;
    for (int i = 0; i < SRC; i++) begin
      pop[i] = wb_v && (gnt == RW'(i));
    end
  end

  always_comb begin
    bus.wb_e_         = 1'b1;
    bus.wb_rob_id     = '0;
    bus.wb_exp_       = 1'b1;
    bus.wb_exp_code   = EXP_NONE;
    bus.wb_pred_miss_ = 1'b1;
    bus.wb_jump_miss_ = 1'b1;
    if (wb_v) begin
      bus.wb_e_         = 1'b0;
      bus.wb_rob_id     = head.rob_id;
      bus.wb_exp_       = head.exp_;
      bus.wb_exp_code   = head.exp_code;
      bus.wb_pred_miss_ = head.pred_miss_;
      bus.wb_jump_miss_ = head.jump_miss_;
    end
  end

  assign bus.src_busy = full;
  assign bus.overflow = ovf_q;

  always_comb begin
    mem_d = mem_q;
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    rr_d  = rr_q;
    ovf_d = ovf_q || (drop != '0);
    for (int i = 0; i < SRC; i++) begin
      if (push[i]) begin
        mem_d[i][wp_q[i]] = in_ent[i];
        wp_d[i] = wp_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rp_d[i] = rp_q[i] + PW'(1);
      end
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (!bus.flush_) begin
        rp_d[i]  = '0;
        wp_d[i]  = '0;
        cnt_d[i] = '0;
      end
    end
    if (wb_v) begin
      rr_d = (gnt == RW'(SRC - 1)) ? '0 : gnt + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < SRC; i++) begin
        rp_q[i]  <= '0;
        wp_q[i]  <= '0;
        cnt_q[i] <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
      rr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: scoreboard of expected writebacks,
// one task per scenario, outputs sampled at the falling edge.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int SRC = 4;
  localparam int ROB = 4;
  localparam int EW  = $bits(ExpCode_t);

  typedef struct packed {
    logic [ROB-1:0] rob;
    logic           exp_;
    ExpCode_t       code;
    logic           pm;
    logic           jm;
  } wb_t;

  logic clk    = 1'b0;
  logic reset_ = 1'b0;

  wb_arbiter_if #(.SRC(SRC), .ROB(ROB)) bus ();

  wb_arbiter #(
    .ROB_DEPTH (16),
    .ROB       (ROB),
    .SRC       (SRC),
    .FIFO_DEPTH(2)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wb_t sb[$];
  wb_t obs;
  wb_t want;
  wb_t idle_v;
  int  n_chk  = 0;
  int  n_fail = 0;

  assign obs = {bus.wb_rob_id, bus.wb_exp_, bus.wb_exp_code,
                bus.wb_pred_miss_, bus.wb_jump_miss_};

  task automatic idle();
    bus.src_e_         = '1;
    bus.src_rob_id     = '0;
    bus.src_exp_       = '1;
    bus.src_exp_code   = '0;
    bus.src_pred_miss_ = '1;
    bus.src_jump_miss_ = '1;
  endtask

  task automatic push(input int s, input logic [ROB-1:0] rob,
                      input logic e, input ExpCode_t c,
                      input logic pm, input logic jm,
                      input bit keep);
    wb_t w;
    bus.src_e_[s]                = 1'b0;
    bus.src_rob_id[s*ROB +: ROB] = rob;
    bus.src_exp_[s]              = e;
    bus.src_exp_code[s*EW +: EW] = c;
    bus.src_pred_miss_[s]        = pm;
    bus.src_jump_miss_[s]        = jm;
    w = '{rob, e, c, pm, jm};
    if (keep) sb.push_back(w);
  endtask

  task automatic do_reset();
    reset_   = 1'b0;
    bus.flush_ = 1'b1;
    idle();
    sb.delete();
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    bus.flush_ = 1'b1;
    idle();
    sb.delete();
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.wb_e_ !== 1'b1 || obs !== idle_v) begin
      n_fail++;
      $display("FAIL reset_wb: wb_e_=%b wb=%h want 1 %h",
               bus.wb_e_, obs, idle_v);
    end
    n_chk++;
    if (bus.src_busy !== 4'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b ovf=%b want 0000 0",
               bus.src_busy, bus.overflow);
    end
    reset_ = 1'b1;
    @(negedge clk);
    push(2, 4'd5, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    #1;
    n_chk++;
    if (bus.wb_e_ !== 1'b1) begin
      n_fail++;
      $display("FAIL single_early: wb_e_=%b want 1", bus.wb_e_);
    end
    @(negedge clk);
    idle();
    want = sb.pop_front();
    n_chk++;
    if (bus.wb_e_ !== 1'b0 || obs !== want) begin
      n_fail++;
      $display("FAIL single_wb: wb_e_=%b wb=%h want 0 %h",
               bus.wb_e_, obs, want);
    end
    @(negedge clk);
    n_chk++;
    if (bus.wb_e_ !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after: wb_e_=%b want 1", bus.wb_e_);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int s = 0; s < SRC; s++) begin
      push(s, ROB'(10 + s), 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      want = sb.pop_front();
      n_chk++;
      if (bus.wb_e_ !== 1'b0 || obs !== want) begin
        n_fail++;
        $display("FAIL rr_order%0d: wb_e_=%b wb=%h want 0 %h",
                 c, bus.wb_e_, obs, want);
      end
      if (c == 3) begin
        push(0, 4'd14, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
        push(3, 4'd15, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
      end
    end
    @(negedge clk);
    n_chk++;
    if (bus.wb_e_ !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain: wb_e_=%b left=%0d want 1 0",
               bus.wb_e_, sb.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push(0, 4'd1, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    push(1, 4'd3, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      want = sb.pop_front();
      n_chk++;
      if (bus.wb_e_ !== 1'b0 || obs !== want) begin
        n_fail++;
        $display("FAIL ovf_wb%0d: wb_e_=%b wb=%h want 0 %h",
                 c, bus.wb_e_, obs, want);
      end
      if (c == 0) begin
        push(0, 4'd2, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
        push(1, 4'd4, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
      end
      if (c == 1) begin
        n_chk++;
        if (bus.src_busy !== 4'b0010 || bus.overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_busy: busy=%b ovf=%b want 0010 0",
                   bus.src_busy, bus.overflow);
        end
        push(1, 4'd5, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b0);
      end
      if (c == 2) begin
        n_chk++;
        if (bus.src_busy !== 4'b0000 || bus.overflow !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_set: busy=%b ovf=%b want 0000 1",
                   bus.src_busy, bus.overflow);
        end
      end
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.wb_e_ !== 1'b1 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: wb_e_=%b ovf=%b want 1 1",
               bus.wb_e_, bus.overflow);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int s = 0; s < SRC; s++) begin
      push(s, ROB'(6 + s), 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    end
    @(negedge clk);
    idle();
    want = sb.pop_front();
    n_chk++;
    if (bus.wb_e_ !== 1'b0 || obs !== want) begin
      n_fail++;
      $display("FAIL flush_pre: wb_e_=%b wb=%h want 0 %h",
               bus.wb_e_, obs, want);
    end
    push(0, 4'd12, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    push(1, 4'd13, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    idle();
    bus.flush_ = 1'b0;
    push(2, 4'd14, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (bus.wb_e_ !== 1'b1 || obs !== idle_v) begin
      n_fail++;
      $display("FAIL flush_cycle: wb_e_=%b wb=%h want 1 %h",
               bus.wb_e_, obs, idle_v);
    end
    sb.delete();
    @(negedge clk);
    bus.flush_ = 1'b1;
    idle();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++;
      if (bus.wb_e_ !== 1'b1 || bus.src_busy !== 4'b0) begin
        n_fail++;
        $display("FAIL flush_after%0d: wb_e_=%b busy=%b want 1 0000",
                 c, bus.wb_e_, bus.src_busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_exception();
    do_reset();
    push(3, 4'd7, 1'b0, EXP_I_MISS_ALIGN, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle();
    want = sb.pop_front();
    n_chk++;
    if (bus.wb_e_ !== 1'b0 || obs !== want) begin
      n_fail++;
      $display("FAIL exp_fields: wb_e_=%b wb=%h want 0 %h",
               bus.wb_e_, obs, want);
    end
    @(negedge clk);
    n_chk++;
    if (bus.wb_e_ !== 1'b1) begin
      n_fail++;
      $display("FAIL exp_single: wb_e_=%b want 1", bus.wb_e_);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(0, 4'd1, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    push(1, 4'd2, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    push(2, 4'd3, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      want = sb.pop_front();
      n_chk++;
      if (bus.wb_e_ !== 1'b0 || obs !== want) begin
        n_fail++;
        $display("FAIL ar_burst%0d: wb_e_=%b wb=%h want 0 %h",
                 c, bus.wb_e_, obs, want);
      end
      if (c == 0) push(1, 4'd4, 1'b1, EXP_NONE, 1'b1, 1'b1, 1'b1);
    end
    n_chk++;
    if (bus.src_busy !== 4'b0010) begin
      n_fail++;
      $display("FAIL ar_busy: busy=%b want 0010", bus.src_busy);
    end
    #2;
    reset_ = 1'b0;
    #1;
    n_chk++;
    if (bus.wb_e_ !== 1'b1 || obs !== idle_v ||
        bus.src_busy !== 4'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_async: wb_e_=%b wb=%h busy=%b ovf=%b want idle",
               bus.wb_e_, obs, bus.src_busy, bus.overflow);
    end
    sb.delete();
    @(negedge clk);
    reset_ = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus.wb_e_ !== 1'b1) begin
        n_fail++;
        $display("FAIL ar_stale%0d: wb_e_=%b rob=%0d want 1",
                 c, bus.wb_e_, bus.wb_rob_id);
      end
    end
  endtask

  initial begin
    idle_v = '{4'd0, 1'b1, EXP_NONE, 1'b1, 1'b1};
    bus.flush_ = 1'b1;
    idle();
    test_reset();
    test_round_robin();
    test_overflow();
    test_flush();
    test_exception();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
